// File: rtl/angle_bin_quantizer_if.sv
// Handshake bundle for angle_bin_quantizer.
//   Request : in_valid/in_ready with signed moments m10 (x), m01 (y).
//   Response: out_valid/out_ready with bin index and quadrant/zero flags.
// master = producer of moments / consumer of results, slave = quantizer.
`timescale 1ns/1ps
interface angle_bin_quantizer_if #(
    parameter int BW_M   = 16,
    parameter int BW_BIN = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [BW_M-1:0]   m10;
    logic [BW_M-1:0]   m01;
    logic              out_valid;
    logic              out_ready;
    logic [BW_BIN-1:0] out_bin;
    logic              out_x_neg;
    logic              out_y_neg;
    logic              out_zero;

    modport master (
        output in_valid, m10, m01, out_ready,
        input  in_ready, out_valid, out_bin, out_x_neg, out_y_neg, out_zero
    );

    modport slave (
        input  in_valid, m10, m01, out_ready,
        output in_ready, out_valid, out_bin, out_x_neg, out_y_neg, out_zero
    );
endinterface

// File: rtl/angle_bin_quantizer.sv
// Orientation bin quantizer for the ORB descriptor path.
// Folds the signed centroid moments (m10, m01) into the first quadrant and
// binary-searches the 25 bins of width pi/50 against a ROM of Q1.11
// boundary cos/sin constants, one probe per cycle for 5 cycles.
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - slave side of angle_bin_quantizer_if (in/out valid-ready
//            handshakes, moments, bin index, sign and zero flags)
`timescale 1ns/1ps
module angle_bin_quantizer #(
    parameter int BW_M   = 16,
    parameter int BW_BIN = 5,
    parameter int BW_C   = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    angle_bin_quantizer_if.slave  bus
);
    localparam int BW_P = BW_M + BW_C;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state_q, state_d;
    logic [BW_M-1:0]   x_q, x_d, y_q, y_d;
    logic              xn_q, xn_d, yn_q, yn_d, zero_q, zero_d;
    logic [BW_BIN-1:0] lo_q, lo_d, hi_q, hi_d, mid;
    logic [2:0]        iter_q, iter_d;
    logic [2*BW_C-1:0] bnd;
    logic [BW_P-1:0]   prod_y, prod_x;
    logic              ge;

    // Boundary k at angle k*pi/50: {C[k], S[k]} = round(2048*{cos, sin}).
    function automatic logic [2*BW_C-1:0] bnd_rom(input logic [BW_BIN-1:0] k);
        logic [2*BW_C-1:0] r;
        case (k)
            5'd1:    r = {12'd2044, 12'd129};
            5'd2:    r = {12'd2032, 12'd257};
            5'd3:    r = {12'd2012, 12'd384};
            5'd4:    r = {12'd1984, 12'd509};
            5'd5:    r = {12'd1948, 12'd633};
            5'd6:    r = {12'd1904, 12'd754};
            5'd7:    r = {12'd1853, 12'd872};
            5'd8:    r = {12'd1795, 12'd987};
            5'd9:    r = {12'd1729, 12'd1097};
            5'd10:   r = {12'd1657, 12'd1204};
            5'd11:   r = {12'd1578, 12'd1305};
            5'd12:   r = {12'd1493, 12'd1402};
            5'd13:   r = {12'd1402, 12'd1493};
            5'd14:   r = {12'd1305, 12'd1578};
            5'd15:   r = {12'd1204, 12'd1657};
            5'd16:   r = {12'd1097, 12'd1729};
            5'd17:   r = {12'd987,  12'd1795};
            5'd18:   r = {12'd872,  12'd1853};
            5'd19:   r = {12'd754,  12'd1904};
            5'd20:   r = {12'd633,  12'd1948};
            5'd21:   r = {12'd509,  12'd1984};
            5'd22:   r = {12'd384,  12'd2012};
            5'd23:   r = {12'd257,  12'd2032};
            5'd24:   r = {12'd129,  12'd2044};
            default: r = {12'd2048, 12'd0};
        endcase
        return r;
    endfunction

    // Upper-middle probe, written as lo + ceil((hi-lo)/2) so it stays in
    // BW_BIN bits; equals (lo+hi+1)>>1.
    assign mid    = lo_q + ((hi_q - lo_q + BW_BIN'(1)) >> 1);
    assign bnd    = bnd_rom(mid);
    // Full-width products: angle >= mid*pi/50 iff Y*C >= X*S (ties go up).
    assign prod_y = BW_P'(y_q) * BW_P'(bnd[2*BW_C-1:BW_C]);
    assign prod_x = BW_P'(x_q) * BW_P'(bnd[BW_C-1:0]);
    assign ge     = (prod_y >= prod_x);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid)     state_d = CALC;
            CALC:    if (iter_q == 3'd4)   state_d = DONE;
            DONE:    if (bus.out_ready)    state_d = IDLE;
            default:                       state_d = IDLE;
        endcase
    end

    // Datapath next-state: capture on accept, one search step per CALC cycle
    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        xn_d   = xn_q;
        yn_d   = yn_q;
        zero_d = zero_q;
        lo_d   = lo_q;
        hi_d   = hi_q;
        iter_d = iter_q;
        case (state_q)
            IDLE: if (bus.in_valid) begin
                // Two's-complement negate; -2^(BW_M-1) lands on 2^(BW_M-1)
                // as an unsigned value.
                x_d    = bus.m10[BW_M-1] ? (~bus.m10) + BW_M'(1) : bus.m10;
                y_d    = bus.m01[BW_M-1] ? (~bus.m01) + BW_M'(1) : bus.m01;
                xn_d   = bus.m10[BW_M-1];
                yn_d   = bus.m01[BW_M-1];
                zero_d = (bus.m10 == '0) && (bus.m01 == '0);
                lo_d   = '0;
                hi_d   = BW_BIN'(24);
                iter_d = '0;
            end
            CALC: begin
                if (lo_q < hi_q) begin
                    if (ge) lo_d = mid;
                    else    hi_d = mid - BW_BIN'(1);
                end
                iter_d = iter_q + 3'd1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q    <= '0;
            y_q    <= '0;
            xn_q   <= 1'b0;
            yn_q   <= 1'b0;
            zero_q <= 1'b0;
            lo_q   <= '0;
            hi_q   <= '0;
            iter_q <= '0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            xn_q   <= xn_d;
            yn_q   <= yn_d;
            zero_q <= zero_d;
            lo_q   <= lo_d;
            hi_q   <= hi_d;
            iter_q <= iter_d;
        end
    end

    // Outputs: result fields are only presented in DONE, zero otherwise
    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == DONE);
        bus.out_bin   = '0;
        bus.out_x_neg = 1'b0;
        bus.out_y_neg = 1'b0;
        bus.out_zero  = 1'b0;
        if (state_q == DONE) begin
            bus.out_bin   = lo_q;
            bus.out_x_neg = xn_q;
            bus.out_y_neg = yn_q;
            bus.out_zero  = zero_q;
        end
    end
endmodule

// File: tb/tb_angle_bin_quantizer.sv
// Self-checking bench for angle_bin_quantizer: directed table, backpressure
// and mid-operation reset sequences, bin-centre / boundary sweep, and random
// moments against a linear-scan reference built from cos/sin boundaries.
`timescale 1ns/1ps
module tb_angle_bin_quantizer;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    angle_bin_quantizer_if #(.BW_M(16), .BW_BIN(5)) bus ();

    angle_bin_quantizer #(.BW_M(16), .BW_BIN(5), .BW_C(12)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int  checks   = 0;
    int  failures = 0;
    int  C_tb [25];
    int  S_tb [25];
    real PI = 3.14159265358979323846;

    typedef struct {
        string name;
        int    m10;
        int    m01;
        int    bin;
        bit    xn;
        bit    yn;
        bit    zr;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: count of boundaries k at or below the point's angle, using
    // exact integer cross-products against the rounded cos/sin constants.
    function automatic int model_bin(input int m10, input int m01);
        longint X, Y;
        int     b;
        X = (m10 < 0) ? -longint'(m10) : longint'(m10);
        Y = (m01 < 0) ? -longint'(m01) : longint'(m01);
        b = 0;
        for (int k = 1; k <= 24; k++)
            if (Y * C_tb[k] >= X * S_tb[k]) b++;
        return b;
    endfunction

    // One full transaction: accept, latency, result fields, handshake.
    task automatic run_sample(input string name, input int m10, input int m01,
                              input int exp_bin, input bit exn, input bit eyn,
                              input bit ezr, input int hold);
        int lat;
        lat = 0;
        while (!bus.in_ready && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({name, "/in_ready"}, bus.in_ready, 1);
        bus.m10       = 16'(m10);
        bus.m01       = 16'(m01);
        bus.in_valid  = 1'b1;
        bus.out_ready = (hold == 0);
        @(negedge clk);
        // Moments must be ignored after the accept edge.
        bus.in_valid = 1'b0;
        bus.m10      = 16'($urandom);
        bus.m01      = 16'($urandom);
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        // Valid appears in the 6th cycle after the accept cycle.
        chk({name, "/latency"}, lat, 5);
        for (int i = 0; i < hold; i++) @(negedge clk);
        bus.out_ready = 1'b1;
        chk({name, "/valid"}, bus.out_valid, 1);
        chk({name, "/bin"},   bus.out_bin,   exp_bin);
        chk({name, "/x_neg"}, bus.out_x_neg, exn);
        chk({name, "/y_neg"}, bus.out_y_neg, eyn);
        chk({name, "/zero"},  bus.out_zero,  ezr);
        @(negedge clk);
        chk({name, "/valid_drop"}, bus.out_valid, 0);
        chk({name, "/ready_back"}, bus.in_ready,  1);
    endtask

    task automatic run_model(input string name, input int m10, input int m01,
                             input int hold);
        run_sample(name, m10, m01, model_bin(m10, m01), m10 < 0, m01 < 0,
                   (m10 == 0) && (m01 == 0), hold);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int x, y;
        real a;

        for (int k = 0; k <= 24; k++) begin
            C_tb[k] = $rtoi($floor(2048.0 * $cos(k * PI / 50.0) + 0.5));
            S_tb[k] = $rtoi($floor(2048.0 * $sin(k * PI / 50.0) + 0.5));
        end

        tbl[0] = '{"x_only",     100,    0,      0,  0, 0, 0};
        tbl[1] = '{"y_only",     0,      100,    24, 0, 0, 0};
        tbl[2] = '{"origin",     0,      0,      24, 0, 0, 1};
        tbl[3] = '{"diag_q3",    -50,    -50,    12, 1, 1, 0};
        tbl[4] = '{"deg30",      1000,   577,    8,  0, 0, 0};
        tbl[5] = '{"xmin",       -32768, 0,      0,  1, 0, 0};
        tbl[6] = '{"ymin",       32767,  -32768, 12, 0, 1, 0};
        tbl[7] = '{"diag_q1",    1000,   1000,   12, 0, 0, 0};
        tbl[8] = '{"deg150",     -1000,  577,    8,  1, 0, 0};

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.m10       = '0;
        bus.m01       = '0;

        #1;
        chk("rst/out_valid", bus.out_valid, 0);
        chk("rst/in_ready",  bus.in_ready,  1);
        chk("rst/out_bin",   bus.out_bin,   0);
        chk("rst/x_neg",     bus.out_x_neg, 0);
        chk("rst/y_neg",     bus.out_y_neg, 0);
        chk("rst/zero",      bus.out_zero,  0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (tbl[i])
            run_sample(tbl[i].name, tbl[i].m10, tbl[i].m01, tbl[i].bin,
                       tbl[i].xn, tbl[i].yn, tbl[i].zr, 0);

        // Backpressure: result held for 10 cycles, extra requests ignored.
        bus.m10 = 16'(1000); bus.m01 = 16'(577);
        bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("bp/latency", lat, 5);
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            bus.m10 = 16'(-5); bus.m01 = 16'(7);
            @(negedge clk);
            chk("bp/valid_held", bus.out_valid, 1);
            chk("bp/bin_held",   bus.out_bin,   8);
            chk("bp/in_ready",   bus.in_ready,  0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp/valid_drop", bus.out_valid, 0);
        chk("bp/ready_back", bus.in_ready,  1);
        repeat (8) @(negedge clk);
        chk("bp/no_ghost", bus.out_valid, 0);

        // Reset during the third CALC cycle discards the work.
        bus.m10 = 16'(500); bus.m01 = 16'(-300); bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst/out_valid", bus.out_valid, 0);
        chk("midrst/in_ready",  bus.in_ready,  1);
        chk("midrst/out_bin",   bus.out_bin,   0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("midrst/no_output", bus.out_valid, 0);
        chk("midrst/idle",      bus.in_ready,  1);
        run_sample("midrst/recover", 1000, 1000, 12, 0, 0, 0, 0);

        // Bin centres at radius 10000.
        for (int k = 0; k <= 24; k++) begin
            a = (k + 0.5) * PI / 50.0;
            x = $rtoi($floor(10000.0 * $cos(a) + 0.5));
            y = $rtoi($floor(10000.0 * $sin(a) + 0.5));
            run_sample($sformatf("centre%0d", k), x, y, k, 0, 0, 0, 0);
        end

        // Exactly on each boundary goes up; one LSB below drops a bin.
        for (int k = 1; k <= 24; k++) begin
            x = C_tb[k] * 10;
            y = S_tb[k] * 10;
            run_sample($sformatf("bnd%0d_on", k),    x, y,     k,     0, 0, 0, 0);
            run_sample($sformatf("bnd%0d_below", k), x, y - 1, k - 1, 0, 0, 0, 0);
            run_sample($sformatf("bnd%0d_above", k), x, y + 1, k,     0, 0, 0, 0);
        end

        // Random moments with random backpressure.
        for (int i = 0; i < 150; i++) begin
            x = int'($urandom_range(0, 65535)) - 32768;
            y = int'($urandom_range(0, 65535)) - 32768;
            case ($urandom_range(0, 7))
                0: x = 0;
                1: y = 0;
                2: x = -32768;
                3: begin x = x / 256; y = y / 256; end
                default: ;
            endcase
            run_model($sformatf("rand%0d", i), x, y, int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
